// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if
// Plot and frame-control bus between the game logic (master) and the
// LED matrix scanner (slave).
//   frame_start : pulse, begin building a new back frame
//   obj_valid   : object plot request
//   obj_ready   : scanner accepts plot requests
//   obj_x       : column index 0..7
//   obj_mask    : row bits to light (1 = lit)
//   obj_color   : {R,G,B} planes to write
//   commit      : pulse, back frame complete, request a swap
//   swapped     : one-cycle pulse when the buffers swap
interface led_matrix_scanner_if;
   logic       frame_start;
   logic       obj_valid;
   logic       obj_ready;
   logic [2:0] obj_x;
   logic [7:0] obj_mask;
   logic [2:0] obj_color;
   logic       commit;
   logic       swapped;

   modport master (
      output frame_start, obj_valid, obj_x, obj_mask, obj_color, commit,
      input  obj_ready, swapped
   );

   modport slave (
      input  frame_start, obj_valid, obj_x, obj_mask, obj_color, commit,
      output obj_ready, swapped
   );
endinterface

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
// Double-buffered 8x8 RGB matrix scanner. Game logic plots objects into the
// back bank; the front bank is scanned column by column onto active-low row
// drives. Banks swap only when the scan wraps from column 7 to column 0, and
// the red-vs-green/blue overlap of the committed frame is reported.
// Ports:
//   CLK           : system clock
//   Clear         : asynchronous active-high reset
//   bus           : plot/frame-control interface (slave modport)
//   frame_overlap : red overlapped blue/green in the displayed frame
//   position_R/G/B: active-low row drive for the current column
//   S             : current column select
// Optional build macro:
//   SCAN_BLANK_EN : blank all rows for the last prescaler cycle of each
//                   column step (ghost suppression); S holds meanwhile.
module led_matrix_scanner #(
   parameter int unsigned SCAN_DIV = 4,
   parameter int unsigned DIV_W    = 8
) (
   input  logic                 CLK,
   input  logic                 Clear,
   led_matrix_scanner_if.slave  bus,
   output logic                 frame_overlap,
   output logic [7:0]           position_R,
   output logic [7:0]           position_G,
   output logic [7:0]           position_B,
   output logic [2:0]           S
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CLEAR     = 2'd1,
      PLOT      = 2'd2,
      WAIT_SWAP = 2'd3
   } state_t;

   state_t state_q, state_nxt;

   // Bank entry layout: {R[23:16], G[15:8], B[7:0]}
   logic [1:0][7:0][23:0] bank_q;
   logic                  front_sel_q;
   logic [DIV_W-1:0]      div_q;
   logic [2:0]            col_q;
   logic [2:0]            clr_col_q;
   logic                  acc_q;

   logic        step_c;
   logic        wrap_c;
   logic        back_sel_c;
   logic        plot_c;
   logic        swap_c;
   logic        hit_c;
   logic        ready_c;
   logic [23:0] back_col_c;
   logic [23:0] front_col_c;
   logic [7:0]  new_r_c, new_g_c, new_b_c;

   // Scan timing
   assign step_c      = (div_q == DIV_W'(SCAN_DIV - 1));
   assign wrap_c      = step_c && (col_q == 3'd7);
   assign back_sel_c  = ~front_sel_q;
   assign front_col_c = bank_q[front_sel_q][col_q];

   // Plot path: planes selected by colour, overlap judged against pre-write column plus this mask
   assign back_col_c = bank_q[back_sel_c][bus.obj_x];
   assign new_r_c    = bus.obj_color[2] ? bus.obj_mask : 8'h00;
   assign new_g_c    = bus.obj_color[1] ? bus.obj_mask : 8'h00;
   assign new_b_c    = bus.obj_color[0] ? bus.obj_mask : 8'h00;
   assign hit_c      = (|(new_r_c & (back_col_c[15:8] | back_col_c[7:0] | new_g_c | new_b_c)))
                     | (|((new_g_c | new_b_c) & back_col_c[23:16]));
   assign plot_c     = (state_q == PLOT) && bus.obj_valid;

   // State register
   always_ff @(posedge CLK or posedge Clear) begin
      if (Clear) state_q <= IDLE;
      else       state_q <= state_nxt;
   end

   // Next state and per-state controls
   always_comb begin
      state_nxt = state_q;
      ready_c   = 1'b0;
      swap_c    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.frame_start) state_nxt = CLEAR;
         end
         CLEAR: begin
            if (clr_col_q == 3'd7) state_nxt = PLOT;
         end
         PLOT: begin
            if (bus.frame_start) state_nxt = CLEAR;
            else if (bus.commit) state_nxt = WAIT_SWAP;
         end
         WAIT_SWAP: begin
            if (wrap_c) begin
               swap_c    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      ready_c = (state_nxt == PLOT);
   end

   // Prescaler and scan column; free-running in every state
   always_ff @(posedge CLK or posedge Clear) begin
      if (Clear) begin
         div_q <= '0;
         col_q <= 3'd0;
      end else if (step_c) begin
         div_q <= '0;
         col_q <= col_q + 3'd1;
      end else begin
         div_q <= div_q + DIV_W'(1);
      end
   end

   // Registered row drives and column select
   always_ff @(posedge CLK or posedge Clear) begin
      if (Clear) begin
         S          <= 3'd0;
         position_R <= 8'hFF;
         position_G <= 8'hFF;
         position_B <= 8'hFF;
      end else begin
`ifdef SCAN_BLANK_EN
         if (step_c) begin
            position_R <= 8'hFF;
            position_G <= 8'hFF;
            position_B <= 8'hFF;
         end else begin
            S          <= col_q;
            position_R <= ~front_col_c[23:16];
            position_G <= ~front_col_c[15:8];
            position_B <= ~front_col_c[7:0];
         end
`else
         S          <= col_q;
         position_R <= ~front_col_c[23:16];
         position_G <= ~front_col_c[15:8];
         position_B <= ~front_col_c[7:0];
`endif
      end
   end

   // Frame banks: back bank cleared/plotted, front bank only read
   always_ff @(posedge CLK or posedge Clear) begin
      if (Clear) begin
         bank_q    <= '0;
         clr_col_q <= 3'd0;
         acc_q     <= 1'b0;
      end else begin
         if (state_q == CLEAR) begin
            bank_q[back_sel_c][clr_col_q] <= 24'h0;
            clr_col_q <= clr_col_q + 3'd1;
            acc_q     <= 1'b0;
         end else begin
            clr_col_q <= 3'd0;
            if (plot_c) begin
               bank_q[back_sel_c][bus.obj_x] <= back_col_c | {new_r_c, new_g_c, new_b_c};
               if (hit_c) acc_q <= 1'b1;
            end
         end
      end
   end

   // Buffer swap, overlap report and handshake outputs
   always_ff @(posedge CLK or posedge Clear) begin
      if (Clear) begin
         front_sel_q   <= 1'b0;
         frame_overlap <= 1'b0;
         bus.swapped   <= 1'b0;
         bus.obj_ready <= 1'b0;
      end else begin
         bus.swapped   <= swap_c;
         bus.obj_ready <= ready_c;
         if (swap_c) begin
            front_sel_q   <= ~front_sel_q;
            frame_overlap <= acc_q;
         end
      end
   end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner
// Scoreboard bench: each committed frame is pushed with its expected overlap
// flag and popped on the wrap where the swap is due; every clock the row
// drives and column select are compared with the frame expected on display.
module tb_led_matrix_scanner;

   localparam int unsigned SCAN_DIV = 4;
   localparam int unsigned PERIOD   = SCAN_DIV * 8;

   typedef struct packed {
      logic            ovl;
      logic [7:0][23:0] cols;
   } frame_t;

   logic       CLK   = 1'b0;
   logic       Clear = 1'b0;
   logic       frame_overlap;
   logic [7:0] position_R, position_G, position_B;
   logic [2:0] S;

   led_matrix_scanner_if bus();

   led_matrix_scanner #(.SCAN_DIV(SCAN_DIV), .DIV_W(8)) dut (
      .CLK           (CLK),
      .Clear         (Clear),
      .bus           (bus.slave),
      .frame_overlap (frame_overlap),
      .position_R    (position_R),
      .position_G    (position_G),
      .position_B    (position_B),
      .S             (S)
   );

   always #5 CLK = ~CLK;

   // Clock edges since the last reset release; defines the scan schedule
   int cyc;
   always @(posedge CLK or posedge Clear) begin
      if (Clear) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   frame_t           sb_q[$];
   logic [7:0][23:0] mback, shown, shown_nxt;
   logic             macc, exp_ovl, pend, shown_upd;
   int               errors = 0;
   int               checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance one clock and compare everything observable against the schedule
   task automatic tick();
      logic [2:0]  c;
      logic        exp_sw;
      logic [23:0] e;
      frame_t      f;
      @(posedge CLK);
      #1;
      if (shown_upd) begin
         shown     = shown_nxt;
         shown_upd = 1'b0;
      end
      exp_sw = pend && (cyc % PERIOD == 0);
      if (exp_sw) begin
         if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
         end else begin
            f         = sb_q.pop_front();
            shown_nxt = f.cols;
            shown_upd = 1'b1;
            exp_ovl   = f.ovl;
         end
         pend = 1'b0;
      end
      check("swapped", 32'(bus.swapped), 32'(exp_sw));
      check("overlap", 32'(frame_overlap), 32'(exp_ovl));
      c = 3'((cyc - 1) / SCAN_DIV);
      e = shown[c];
`ifdef SCAN_BLANK_EN
      if (cyc % SCAN_DIV == 0) e = 24'h0;
`endif
      check("scan", {5'h0, S, position_R, position_G, position_B}, {5'h0, c, ~e});
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_pos"},   {8'h0, position_R, position_G, position_B}, 32'h00FF_FFFF);
      check({tag, "_S"},     32'(S), 32'd0);
      check({tag, "_ready"}, 32'(bus.obj_ready), 32'd0);
      check({tag, "_swap"},  32'(bus.swapped), 32'd0);
      check({tag, "_ovl"},   32'(frame_overlap), 32'd0);
   endtask

   task automatic start_frame();
      int n;
      bus.frame_start = 1'b1;
      mback = '0;
      macc  = 1'b0;
      tick();
      bus.frame_start = 1'b0;
      n = 0;
      while (!bus.obj_ready && n < 40) begin
         tick();
         n++;
      end
      check("clear_len", 32'(n), 32'd8);
   endtask

   task automatic plot(input logic [2:0] x, input logic [7:0] mask,
                       input logic [2:0] color, input logic with_commit);
      logic [23:0] old;
      logic [7:0]  nr, ng, nb;
      old = mback[x];
      nr  = color[2] ? mask : 8'h00;
      ng  = color[1] ? mask : 8'h00;
      nb  = color[0] ? mask : 8'h00;
      if (((nr & (old[15:8] | old[7:0] | ng | nb)) != 8'h00) ||
          (((ng | nb) & old[23:16]) != 8'h00)) macc = 1'b1;
      mback[x] = old | {nr, ng, nb};
      bus.obj_valid = 1'b1;
      bus.obj_x     = x;
      bus.obj_mask  = mask;
      bus.obj_color = color;
      bus.commit    = with_commit;
      tick();
      bus.obj_valid = 1'b0;
      bus.commit    = 1'b0;
      if (with_commit) begin
         sb_q.push_back({macc, mback});
         pend = 1'b1;
         check("ready_after_commit", 32'(bus.obj_ready), 32'd0);
      end
   endtask

   task automatic do_commit();
      bus.commit = 1'b1;
      tick();
      bus.commit = 1'b0;
      sb_q.push_back({macc, mback});
      pend = 1'b1;
      check("ready_after_commit", 32'(bus.obj_ready), 32'd0);
   endtask

   task automatic wait_swap();
      int n;
      n = 0;
      while (pend && n < 2 * PERIOD + 4) begin
         tick();
         n++;
      end
   endtask

   initial begin
      bus.frame_start = 1'b0;
      bus.obj_valid   = 1'b0;
      bus.obj_x       = 3'd0;
      bus.obj_mask    = 8'h00;
      bus.obj_color   = 3'b000;
      bus.commit      = 1'b0;
      mback = '0; shown = '0; shown_nxt = '0;
      macc = 1'b0; exp_ovl = 1'b0; pend = 1'b0; shown_upd = 1'b0;

      #1 Clear = 1'b1;
      #2 reset_checks("rst0");
      repeat (2) @(posedge CLK);
      @(negedge CLK) Clear = 1'b0;
      repeat (PERIOD) tick();

      // Single red object at column 3
      start_frame();
      plot(3'd3, 8'b0000_0011, 3'b100, 1'b0);
      do_commit();
      wait_swap();
      repeat (PERIOD) tick();

      // Red then blue on column 5: overlap
      start_frame();
      plot(3'd5, 8'h0C, 3'b100, 1'b0);
      plot(3'd5, 8'h08, 3'b001, 1'b0);
      do_commit();
      wait_swap();
      repeat (PERIOD) tick();

      // Frame in progress keeps old display; abort via frame_start; plot+commit together
      start_frame();
      plot(3'd1, 8'hFF, 3'b111, 1'b0);
      repeat (40) tick();
      start_frame();
      plot(3'd0, 8'h80, 3'b010, 1'b1);
      wait_swap();
      repeat (PERIOD) tick();

      // Commit while idle must not swap
      bus.commit = 1'b1;
      tick();
      bus.commit = 1'b0;
      repeat (PERIOD + 8) tick();

      // Asynchronous reset mid-scan while plotting, front holding data
      start_frame();
      plot(3'd2, 8'h55, 3'b001, 1'b0);
      repeat (5) tick();
      #2 Clear = 1'b1;
      #1 reset_checks("rst_mid");
      shown = '0; shown_upd = 1'b0; exp_ovl = 1'b0; pend = 1'b0;
      sb_q.delete();
      @(posedge CLK);
      @(negedge CLK) Clear = 1'b0;
      repeat (PERIOD + 4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
